// File: rtl/rd_ptr_handler.sv
// Read-side pointer manager for the asynchronous FIFO (read clock domain).
// Keeps binary and Gray read pointers and drives the memory read address.
// Derives empty, almost_empty, occupancy and a sticky underflow flag from
// the write Gray pointer, which arrives already synchronized into rclk.
module rd_ptr_handler #(
   parameter int PTR_WIDTH = 4,
   parameter int AE_THRESH = 2
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic                 r_en,
   input  logic [PTR_WIDTH-1:0] gray_wptr,
   output logic [PTR_WIDTH-1:0] binary_rptr,
   output logic [PTR_WIDTH-1:0] gray_rptr,
   output logic [PTR_WIDTH-2:0] rd_addr,
   output logic                 empty,
   output logic                 almost_empty,
   output logic [PTR_WIDTH-1:0] rd_count,
   output logic                 underflow
);

   localparam logic [PTR_WIDTH-1:0] AE_LEVEL = PTR_WIDTH'(AE_THRESH);

   logic                 rd_acc;
   logic [PTR_WIDTH-1:0] binary_rptr_p;
   logic [PTR_WIDTH-1:0] gray_rptr_p;
   logic [PTR_WIDTH-1:0] wbin;
   logic [PTR_WIDTH-1:0] count_p;

   // Next-state pointers: a read is only accepted while not empty.
   always_comb begin
      rd_acc        = r_en & ~empty;
      binary_rptr_p = binary_rptr + {{(PTR_WIDTH-1){1'b0}}, rd_acc};
      gray_rptr_p   = binary_rptr_p ^ (binary_rptr_p >> 1);
   end

   // Gray-to-binary decode of the write pointer, MSB-first XOR prefix.
   always_comb begin
      wbin = '0;
      wbin[PTR_WIDTH-1] = gray_wptr[PTR_WIDTH-1];
      for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
         wbin[i] = wbin[i+1] ^ gray_wptr[i];
      end
   end

   // Occupancy after this cycle's read and write-pointer movement; the wrap
   // bit makes a completely full FIFO distinguishable from an empty one.
   always_comb begin
      count_p = wbin - binary_rptr_p;
   end

   // Pointer and flag registers; the flags look at next-state pointers so
   // empty rises on the same edge that consumes the last word.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         binary_rptr  <= '0;
         gray_rptr    <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_count     <= '0;
         underflow    <= 1'b0;
      end else begin
         binary_rptr  <= binary_rptr_p;
         gray_rptr    <= gray_rptr_p;
         empty        <= (gray_rptr_p == gray_wptr);
         almost_empty <= (count_p <= AE_LEVEL);
         rd_count     <= count_p;
         underflow    <= underflow | (r_en & empty);
      end
   end

   assign rd_addr = binary_rptr[PTR_WIDTH-2:0];

endmodule

// File: tb/tb_rd_ptr_handler.sv
// Directed bench for rd_ptr_handler: stimulus pushes hand-computed
// expectations into a queue, an independent monitor pops and compares.
module tb_rd_ptr_handler;

   localparam int PW = 4;

   logic          rclk;
   logic          rrst;
   logic          r_en;
   logic [PW-1:0] gray_wptr;
   logic [PW-1:0] binary_rptr;
   logic [PW-1:0] gray_rptr;
   logic [PW-2:0] rd_addr;
   logic          empty;
   logic          almost_empty;
   logic [PW-1:0] rd_count;
   logic          underflow;

   rd_ptr_handler #(.PTR_WIDTH(PW), .AE_THRESH(2)) dut (
      .rclk         (rclk),
      .rrst         (rrst),
      .r_en         (r_en),
      .gray_wptr    (gray_wptr),
      .binary_rptr  (binary_rptr),
      .gray_rptr    (gray_rptr),
      .rd_addr      (rd_addr),
      .empty        (empty),
      .almost_empty (almost_empty),
      .rd_count     (rd_count),
      .underflow    (underflow)
   );

   typedef struct {
      string         name;
      logic [PW-1:0] b;
      logic [PW-1:0] g;
      logic          e;
      logic          ae;
      logic [PW-1:0] c;
      logic          uf;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   // Apply one vector for one clock edge, then queue what must be seen.
   task automatic step(input string name, input logic rst, input logic ren,
                       input logic [PW-1:0] gw, input logic [PW-1:0] b,
                       input logic [PW-1:0] g, input logic e, input logic ae,
                       input logic [PW-1:0] c, input logic uf);
      exp_t x;
      @(negedge rclk);
      rrst      = rst;
      r_en      = ren;
      gray_wptr = gw;
      @(posedge rclk);
      #1;
      x.name = name; x.b = b; x.g = g; x.e = e; x.ae = ae; x.c = c; x.uf = uf;
      q.push_back(x);
   endtask

   // Monitor: compare every queued expectation mid-cycle.
   initial begin
      exp_t        x;
      logic [PW-2:0] a_exp;
      forever begin
         @(negedge rclk);
         if (q.size() > 0) begin
            x = q.pop_front();
            a_exp = x.b[PW-2:0];
            n_vec++;
            if (binary_rptr !== x.b || gray_rptr !== x.g || rd_addr !== a_exp ||
                empty !== x.e || almost_empty !== x.ae || rd_count !== x.c ||
                underflow !== x.uf) begin
               n_bad++;
               $display("FAIL %s: got b=%h g=%b a=%h e=%b ae=%b c=%0d uf=%b, want b=%h g=%b a=%h e=%b ae=%b c=%0d uf=%b",
                        x.name, binary_rptr, gray_rptr, rd_addr, empty, almost_empty,
                        rd_count, underflow, x.b, x.g, a_exp, x.e, x.ae, x.c, x.uf);
            end
         end
      end
   end

   initial begin
      int budget;
      rrst = 1'b1; r_en = 1'b0; gray_wptr = '0;
      //      name         rst ren gw        b        g        e  ae  c   uf
      step("reset",        1, 1, 4'b0010, 4'd0,  4'b0000, 1, 1, 4'd0, 0);
      step("fill3",        0, 0, 4'b0010, 4'd0,  4'b0000, 0, 0, 4'd3, 0);
      step("drain1",       0, 1, 4'b0010, 4'd1,  4'b0001, 0, 1, 4'd2, 0);
      step("drain2",       0, 1, 4'b0010, 4'd2,  4'b0011, 0, 1, 4'd1, 0);
      step("drain3",       0, 1, 4'b0010, 4'd3,  4'b0010, 1, 1, 4'd0, 0);
      step("underflow",    0, 1, 4'b0010, 4'd3,  4'b0010, 1, 1, 4'd0, 1);
      step("uf_write",     0, 0, 4'b0110, 4'd3,  4'b0010, 0, 1, 4'd1, 1);
      step("uf_sticky",    0, 1, 4'b0110, 4'd4,  4'b0110, 1, 1, 4'd0, 1);
      step("uf_clear",     1, 0, 4'b0000, 4'd0,  4'b0000, 1, 1, 4'd0, 0);
      step("full8",        0, 0, 4'b1100, 4'd0,  4'b0000, 0, 0, 4'd8, 0);
      step("lap1_r1",      0, 1, 4'b1100, 4'd1,  4'b0001, 0, 0, 4'd7, 0);
      step("lap1_r2",      0, 1, 4'b1100, 4'd2,  4'b0011, 0, 0, 4'd6, 0);
      step("lap1_r3",      0, 1, 4'b1100, 4'd3,  4'b0010, 0, 0, 4'd5, 0);
      step("lap1_r4",      0, 1, 4'b1100, 4'd4,  4'b0110, 0, 0, 4'd4, 0);
      step("lap1_r5",      0, 1, 4'b1100, 4'd5,  4'b0111, 0, 0, 4'd3, 0);
      step("lap1_r6",      0, 1, 4'b1100, 4'd6,  4'b0101, 0, 1, 4'd2, 0);
      step("lap1_r7",      0, 1, 4'b1100, 4'd7,  4'b0100, 0, 1, 4'd1, 0);
      step("lap1_r8",      0, 1, 4'b1100, 4'd8,  4'b1100, 1, 1, 4'd0, 0);
      step("lap2_fill",    0, 0, 4'b1000, 4'd8,  4'b1100, 0, 0, 4'd7, 0);
      step("lap2_r1",      0, 1, 4'b1000, 4'd9,  4'b1101, 0, 0, 4'd6, 0);
      step("lap2_r2",      0, 1, 4'b1000, 4'd10, 4'b1111, 0, 0, 4'd5, 0);
      step("lap2_r3",      0, 1, 4'b1000, 4'd11, 4'b1110, 0, 0, 4'd4, 0);
      step("lap2_r4",      0, 1, 4'b1000, 4'd12, 4'b1010, 0, 0, 4'd3, 0);
      step("lap2_r5",      0, 1, 4'b1000, 4'd13, 4'b1011, 0, 1, 4'd2, 0);
      step("lap2_r6",      0, 1, 4'b1000, 4'd14, 4'b1001, 0, 1, 4'd1, 0);
      step("lap2_r7",      0, 1, 4'b1000, 4'd15, 4'b1000, 1, 1, 4'd0, 0);
      step("wrap_fill",    0, 0, 4'b0000, 4'd15, 4'b1000, 0, 1, 4'd1, 0);
      step("wrap_read",    0, 1, 4'b0000, 4'd0,  4'b0000, 1, 1, 4'd0, 0);
      step("sim_fill4",    0, 0, 4'b0110, 4'd0,  4'b0000, 0, 0, 4'd4, 0);
      step("sim_rw1",      0, 1, 4'b0111, 4'd1,  4'b0001, 0, 0, 4'd4, 0);
      step("sim_rw2",      0, 1, 4'b0101, 4'd2,  4'b0011, 0, 0, 4'd4, 0);
      step("stream_r3",    0, 1, 4'b0101, 4'd3,  4'b0010, 0, 0, 4'd3, 0);
      step("stream_r4",    0, 1, 4'b0101, 4'd4,  4'b0110, 0, 1, 4'd2, 0);
      step("stream_r5",    0, 1, 4'b0101, 4'd5,  4'b0111, 0, 1, 4'd1, 0);
      step("mid_reset",    1, 1, 4'b0000, 4'd0,  4'b0000, 1, 1, 4'd0, 0);
      step("post_rst1",    0, 0, 4'b0000, 4'd0,  4'b0000, 1, 1, 4'd0, 0);
      step("post_rst2",    0, 0, 4'b0000, 4'd0,  4'b0000, 1, 1, 4'd0, 0);

      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(posedge rclk);
         budget++;
      end
      if (q.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
